// File: rtl/dphy_lane_sequencer.sv
// D-PHY data-lane burst sequencer: walks LP-11 -> LP-01 -> LP-00 -> HS-zero -> HS data -> HS-trail -> LP-11.
// PHY outputs and event pulses are registered, so they show each cycle's state one clock later.
//
// state      | meaning
// -----------+-------------------------------------------------
// S_IDLE     | LP-11 stop state, waiting for lanes_enable & hs_req
// S_LP01     | HS request (LP-01), tlpx cycles
// S_LP00     | HS prepare (LP-00), hs_prepare cycles
// S_HS_ZERO  | HS-zero preamble, hs_go cycles
// S_HS_DATA  | payload bytes, hs_ready high, ends on first idle beat
// S_HS_TRAIL | trail (inverse of last bit), hs_trail cycles
// S_HS_EXIT  | LP-11 hold after burst, hs_exit cycles
module dphy_lane_sequencer #(
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lanes_enable,
    input  logic [2:0]           lanes_number,
    input  logic [CNT_W-1:0]     tlpx_timeout,
    input  logic [CNT_W-1:0]     hs_prepare_timeout,
    input  logic [CNT_W-1:0]     hs_go_timeout,
    input  logic [CNT_W-1:0]     hs_trail_timeout,
    input  logic [CNT_W-1:0]     hs_exit_timeout,
    input  logic                 hs_req,
    input  logic                 hs_valid,
    input  logic [8*LANES-1:0]   hs_data,
    output logic                 hs_ready,
    output logic [LANES-1:0]     lp_p,
    output logic [LANES-1:0]     lp_n,
    output logic [LANES-1:0]     hs_oe,
    output logic [8*LANES-1:0]   hs_dout,
    output logic                 busy,
    output logic                 burst_done,
    output logic                 underflow_set
);

    typedef enum logic [2:0] {
        S_IDLE, S_LP01, S_LP00, S_HS_ZERO, S_HS_DATA, S_HS_TRAIL, S_HS_EXIT
    } state_t;

    localparam logic [2:0] LANES_L = 3'(LANES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   prep_q, prep_d;
    logic [CNT_W-1:0]   go_q, go_d;
    logic [CNT_W-1:0]   trail_q, trail_d;
    logic [CNT_W-1:0]   exit_q, exit_d;
    logic [2:0]         lanes_q, lanes_d;
    logic [8*LANES-1:0] last_q, last_d;
    logic [LANES-1:0]   lp_p_q, lp_p_d;
    logic [LANES-1:0]   lp_n_q, lp_n_d;
    logic [LANES-1:0]   hs_oe_q, hs_oe_d;
    logic [8*LANES-1:0] hs_dout_q, hs_dout_d;
    logic               busy_q, busy_d;
    logic               burst_done_q, burst_done_d;
    logic               underflow_q, underflow_d;

    logic               xfer;
    logic               tc;
    logic [2:0]         lanes_eff;
    logic [8*LANES-1:0] data_now;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] t);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    assign hs_ready = (state_q == S_HS_DATA);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prep_d       = prep_q;
        go_d         = go_q;
        trail_d      = trail_q;
        exit_d       = exit_q;
        lanes_d      = lanes_q;
        last_d       = last_q;
        burst_done_d = 1'b0;
        underflow_d  = 1'b0;

        xfer      = (state_q == S_HS_DATA) && hs_valid && lanes_enable;
        tc        = (cnt_q == CNT_W'(1));
        lanes_eff = (lanes_number == 3'd0 || lanes_number > LANES_L) ? LANES_L : lanes_number;
        data_now  = xfer ? hs_data : last_q;

        case (state_q)
            S_IDLE: begin
                if (lanes_enable && hs_req) begin
                    // tlpx goes straight into the counter; the rest wait for their state
                    state_d = S_LP01;
                    cnt_d   = at_least_one(tlpx_timeout);
                    prep_d  = hs_prepare_timeout;
                    go_d    = hs_go_timeout;
                    trail_d = hs_trail_timeout;
                    exit_d  = hs_exit_timeout;
                    lanes_d = lanes_eff;
                    last_d  = '0;
                end
            end
            S_LP01: begin
                if (tc) begin
                    state_d = S_LP00;
                    cnt_d   = at_least_one(prep_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LP00: begin
                if (tc) begin
                    state_d = S_HS_ZERO;
                    cnt_d   = at_least_one(go_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HS_ZERO: begin
                if (tc) begin
                    state_d = S_HS_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HS_DATA: begin
                if (xfer) begin
                    last_d = hs_data;
                end
                if (!lanes_enable || !hs_valid) begin
                    state_d     = S_HS_TRAIL;
                    cnt_d       = at_least_one(trail_q);
                    underflow_d = lanes_enable && hs_req;
                end
            end
            S_HS_TRAIL: begin
                if (tc) begin
                    state_d = S_HS_EXIT;
                    cnt_d   = at_least_one(exit_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HS_EXIT: begin
                if (tc) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    burst_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        lp_p_d    = '1;
        lp_n_d    = '1;
        hs_oe_d   = '0;
        hs_dout_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(lanes_q)) begin
                case (state_q)
                    S_LP01: begin
                        lp_p_d[i] = 1'b0;
                    end
                    S_LP00: begin
                        lp_p_d[i] = 1'b0;
                        lp_n_d[i] = 1'b0;
                    end
                    S_HS_ZERO: begin
                        lp_p_d[i]  = 1'b0;
                        lp_n_d[i]  = 1'b0;
                        hs_oe_d[i] = 1'b1;
                    end
                    S_HS_DATA: begin
                        lp_p_d[i]          = 1'b0;
                        lp_n_d[i]          = 1'b0;
                        hs_oe_d[i]         = 1'b1;
                        hs_dout_d[8*i +: 8] = data_now[8*i +: 8];
                    end
                    S_HS_TRAIL: begin
                        lp_p_d[i]          = 1'b0;
                        lp_n_d[i]          = 1'b0;
                        hs_oe_d[i]         = 1'b1;
                        hs_dout_d[8*i +: 8] = {8{~last_q[8*i+7]}};
                    end
                    default: begin
                        lp_p_d[i] = 1'b1;
                        lp_n_d[i] = 1'b1;
                    end
                endcase
            end
        end

        busy_d = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            prep_q       <= '0;
            go_q         <= '0;
            trail_q      <= '0;
            exit_q       <= '0;
            lanes_q      <= '0;
            last_q       <= '0;
            lp_p_q       <= '1;
            lp_n_q       <= '1;
            hs_oe_q      <= '0;
            hs_dout_q    <= '0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prep_q       <= prep_d;
            go_q         <= go_d;
            trail_q      <= trail_d;
            exit_q       <= exit_d;
            lanes_q      <= lanes_d;
            last_q       <= last_d;
            lp_p_q       <= lp_p_d;
            lp_n_q       <= lp_n_d;
            hs_oe_q      <= hs_oe_d;
            hs_dout_q    <= hs_dout_d;
            busy_q       <= busy_d;
            burst_done_q <= burst_done_d;
            underflow_q  <= underflow_d;
        end
    end

    assign lp_p          = lp_p_q;
    assign lp_n          = lp_n_q;
    assign hs_oe         = hs_oe_q;
    assign hs_dout       = hs_dout_q;
    assign busy          = busy_q;
    assign burst_done    = burst_done_q;
    assign underflow_set = underflow_q;

endmodule

// File: tb/tb_dphy_lane_sequencer.sv
// Scoreboard bench: each burst pushes its expected phase plan; a monitor replays it cycle by cycle.
module tb_dphy_lane_sequencer;

    localparam int LANES = 4;
    localparam int K_LP01 = 0, K_LP00 = 1, K_ZERO = 2, K_DATA = 3, K_TRAIL = 4, K_EXIT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lanes_enable;
    logic [2:0]  lanes_number;
    logic [7:0]  tlpx_timeout, hs_prepare_timeout, hs_go_timeout, hs_trail_timeout, hs_exit_timeout;
    logic        hs_req, hs_valid;
    logic [31:0] hs_data;
    logic        hs_ready;
    logic [3:0]  lp_p, lp_n, hs_oe;
    logic [31:0] hs_dout;
    logic        busy, burst_done, underflow_set;

    typedef struct packed {
        logic [7:0]   t1, t2, t3, t4, t5;
        logic [2:0]   lanes;
        logic [3:0]   n;
        logic [255:0] beats;
        logic         uf;
    } burst_t;

    burst_t exp_q[$];
    int     total = 0;
    int     bad = 0;
    bit     mon_en = 1'b1;

    dphy_lane_sequencer #(.LANES(LANES), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .lanes_enable(lanes_enable), .lanes_number(lanes_number),
        .tlpx_timeout(tlpx_timeout), .hs_prepare_timeout(hs_prepare_timeout),
        .hs_go_timeout(hs_go_timeout), .hs_trail_timeout(hs_trail_timeout),
        .hs_exit_timeout(hs_exit_timeout), .hs_req(hs_req), .hs_valid(hs_valid),
        .hs_data(hs_data), .hs_ready(hs_ready), .lp_p(lp_p), .lp_n(lp_n), .hs_oe(hs_oe),
        .hs_dout(hs_dout), .busy(busy), .burst_done(burst_done), .underflow_set(underflow_set)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m1(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

    function automatic logic [2:0] eff_lanes(input logic [2:0] n);
        return (n == 3'd0 || n > 3'd4) ? 3'd4 : n;
    endfunction

    // Expected {lp_p, lp_n, hs_oe, hs_dout} for a line phase; d is the byte word the phase shows.
    function automatic logic [43:0] exp_vec(input int kind, input int lanes, input logic [31:0] d);
        logic [3:0]  p, n, oe;
        logic [31:0] b;
        p = '1; n = '1; oe = '0; b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < lanes) begin
                case (kind)
                    K_LP01:  p[i] = 1'b0;
                    K_LP00:  begin p[i] = 1'b0; n[i] = 1'b0; end
                    K_ZERO:  begin p[i] = 1'b0; n[i] = 1'b0; oe[i] = 1'b1; end
                    K_DATA:  begin p[i] = 1'b0; n[i] = 1'b0; oe[i] = 1'b1; b[8*i +: 8] = d[8*i +: 8]; end
                    K_TRAIL: begin p[i] = 1'b0; n[i] = 1'b0; oe[i] = 1'b1; b[8*i +: 8] = {8{~d[8*i+7]}}; end
                    default: ;
                endcase
            end
        end
        return {p, n, oe, b};
    endfunction

    task automatic chk(input int kind, input int lanes, input logic [31:0] d,
                       input logic bd, input logic uf, input string nm);
        logic [43:0] e, a;
        e = exp_vec(kind, lanes, d);
        a = {lp_p, lp_n, hs_oe, hs_dout};
        total++;
        if (a !== e || busy !== 1'b1 || burst_done !== bd || underflow_set !== uf) begin
            bad++;
            $display("FAIL %s: phy got=%h want=%h busy got=%b want=1 done got=%b want=%b uf got=%b want=%b",
                     nm, a, e, busy, burst_done, bd, underflow_set, uf);
        end
    endtask

    task automatic mon_burst();
        burst_t      b;
        logic [31:0] last;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_burst: got busy=1 want no burst queued");
            while (busy === 1'b1) @(negedge clk);
            return;
        end
        b = exp_q.pop_front();
        for (int j = 0; j < b.t1; j++) begin chk(K_LP01, b.lanes, 0, 0, 0, "lp01"); @(negedge clk); end
        for (int j = 0; j < b.t2; j++) begin chk(K_LP00, b.lanes, 0, 0, 0, "lp00"); @(negedge clk); end
        for (int j = 0; j < b.t3; j++) begin chk(K_ZERO, b.lanes, 0, 0, 0, "hs_zero"); @(negedge clk); end
        for (int j = 0; j < b.n; j++) begin
            chk(K_DATA, b.lanes, b.beats[32*j +: 32], 0, 0, "hs_data");
            @(negedge clk);
        end
        last = (b.n == 0) ? 32'h0 : b.beats[32*(b.n-1) +: 32];
        chk(K_DATA, b.lanes, last, 0, b.uf, "hs_data_end");
        @(negedge clk);
        for (int j = 0; j < b.t4; j++) begin chk(K_TRAIL, b.lanes, last, 0, 0, "hs_trail"); @(negedge clk); end
        for (int j = 0; j < b.t5; j++) begin
            chk(K_EXIT, b.lanes, 0, (j == b.t5 - 1), 0, "hs_exit");
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0 || burst_done !== 1'b0 || lp_p !== 4'hF || lp_n !== 4'hF || hs_oe !== 4'h0) begin
            bad++;
            $display("FAIL post_idle: got busy=%b done=%b lp_p=%h lp_n=%h oe=%h want 0 0 f f 0",
                     busy, burst_done, lp_p, lp_n, hs_oe);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && busy === 1'b1) mon_burst();
        end
    end

    task automatic summary_and_finish();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic scramble_csr();
        tlpx_timeout       = 8'($urandom);
        hs_prepare_timeout = 8'($urandom);
        hs_go_timeout      = 8'($urandom);
        hs_trail_timeout   = 8'($urandom);
        hs_exit_timeout    = 8'($urandom);
        lanes_number       = 3'($urandom);
    endtask

    // mode: 0 normal end, 1 underflow (hs_req held), 2 lanes_enable dropped during LP
    task automatic do_burst(input logic [7:0] tl, tp, tg, tt, te, input logic [2:0] ln,
                            input int n, input logic [255:0] beats, input int mode, input bit reentry);
        burst_t b;
        int     cyc, lat;
        bit     got;
        tlpx_timeout = tl; hs_prepare_timeout = tp; hs_go_timeout = tg;
        hs_trail_timeout = tt; hs_exit_timeout = te; lanes_number = ln;
        lanes_enable = 1'b1; hs_req = 1'b1; hs_valid = 1'b0;
        b.t1 = m1(tl); b.t2 = m1(tp); b.t3 = m1(tg); b.t4 = m1(tt); b.t5 = m1(te);
        b.lanes = eff_lanes(ln);
        b.n = (mode == 2) ? 4'd0 : 4'(n);
        b.beats = beats;
        b.uf = (mode == 1);
        exp_q.push_back(b);
        lat = int'(b.t1) + int'(b.t2) + int'(b.t3) + 1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (mode == 2) lanes_enable = 1'b0;
            if (hs_ready === 1'b1) got = 1'b1;
            else scramble_csr();
        end
        total++;
        if (!got || cyc != lat) begin
            bad++;
            $display("FAIL ready_latency: got=%0d want=%0d", cyc, lat);
            if (!got) summary_and_finish();
        end
        if (mode == 2) begin
            hs_valid = 1'b1; hs_data = $urandom;
            @(negedge clk);
            lanes_enable = 1'b1; hs_valid = 1'b0; hs_req = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                hs_valid = 1'b1; hs_data = beats[32*i +: 32];
                @(negedge clk);
            end
            hs_valid = 1'b0; hs_data = $urandom; hs_req = (mode == 1);
            @(negedge clk);
            if (!reentry) hs_req = 1'b0;
        end
        cyc = 0;
        while (burst_done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (burst_done !== 1'b1) begin
            total++; bad++;
            $display("FAIL burst_done_timeout: got no pulse within %0d cycles want pulse", cyc);
            summary_and_finish();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [255:0] bt;
        int           cyc;
        bit           seen;
        rst_n = 1'b0; lanes_enable = 1'b1; hs_req = 1'b1; hs_valid = 1'b1; hs_data = 32'hFFFF_FFFF;
        lanes_number = 3'd4;
        tlpx_timeout = 8; hs_prepare_timeout = 15; hs_go_timeout = 30;
        hs_trail_timeout = 2; hs_exit_timeout = 3;
        repeat (3) @(negedge clk);
        total++;
        if ({lp_p, lp_n, hs_oe, hs_dout} !== {4'hF, 4'hF, 4'h0, 32'h0} ||
            {hs_ready, busy, burst_done, underflow_set} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state: got lp_p=%h lp_n=%h oe=%h dout=%h rdy=%b busy=%b done=%b uf=%b",
                     lp_p, lp_n, hs_oe, hs_dout, hs_ready, busy, burst_done, underflow_set);
        end
        hs_req = 1'b0; hs_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        bt = 256'({32'h4455_6677, 32'h3344_5566, 32'h2233_4455, 32'h1122_3344});
        do_burst(8, 15, 30, 2, 3, 3'd4, 4, bt, 0, 1'b0);
        @(negedge clk);
        bt = 256'({32'hC3A5_0F81, 32'h7E01_9922, 32'h8001_FF7F});
        do_burst(0, 0, 0, 0, 0, 3'd4, 3, bt, 0, 1'b0);
        @(negedge clk);
        bt = 256'({32'hFFFF_8080, 32'h5A5A_8080});
        do_burst(3, 2, 4, 2, 2, 3'd2, 2, bt, 0, 1'b0);
        @(negedge clk);
        bt = 256'({32'h0102_0304, 32'h8899_AABB, 32'h7F80_7F80});
        do_burst(4, 3, 5, 2, 2, 3'd4, 3, bt, 1, 1'b1);
        do_burst(8, 6, 4, 1, 1, 3'd0, 1, 256'(32'hDEAD_BEEF), 0, 1'b0);
        @(negedge clk);
        do_burst(2, 1, 1, 1, 1, 3'd7, 1, 256'(32'h0000_0080), 0, 1'b0);
        @(negedge clk);
        do_burst(3, 3, 3, 2, 2, 3'd3, 0, 256'(0), 2, 1'b0);
        @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            int mode, nb;
            bit re;
            for (int i = 0; i < 8; i++) bt[32*i +: 32] = $urandom;
            mode = $urandom_range(0, 2);
            nb   = $urandom_range(0, 6);
            re   = (mode == 1) && (k != 29) && ($urandom_range(0, 1) == 1);
            do_burst(8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)),
                     8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 3'($urandom_range(0, 7)),
                     nb, bt, mode, re);
            if (!re) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending bursts want 0", exp_q.size());
        end

        // Reset in the middle of HS data
        mon_en = 1'b0;
        tlpx_timeout = 2; hs_prepare_timeout = 2; hs_go_timeout = 2;
        hs_trail_timeout = 2; hs_exit_timeout = 2; lanes_number = 3'd4;
        lanes_enable = 1'b1; hs_req = 1'b1;
        cyc = 0;
        while (hs_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        hs_valid = 1'b1; hs_data = 32'h8182_8384;
        @(negedge clk);
        hs_data = 32'h1111_2222;
        @(negedge clk);
        rst_n = 1'b0; hs_valid = 1'b0; hs_req = 1'b0;
        @(negedge clk);
        total++;
        if ({lp_p, lp_n, hs_oe, hs_dout} !== {4'hF, 4'hF, 4'h0, 32'h0} ||
            {hs_ready, busy, burst_done, underflow_set} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_burst_reset: got lp_p=%h lp_n=%h oe=%h dout=%h rdy=%b busy=%b done=%b uf=%b",
                     lp_p, lp_n, hs_oe, hs_dout, hs_ready, busy, burst_done, underflow_set);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (burst_done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL post_reset_quiet: got activity after reset want busy=0 done=0");
        end
        summary_and_finish();
    end

endmodule

// File: doc/dphy_lane_sequencer.md
Name: dphy_lane_sequencer

Overview:
- Per-burst LP→HS→LP sequencer for the D-PHY data lanes.
- Sits between the packet assembler (byte stream plus burst request) and the lane serializers/LP drivers.
- Driven by the control/timing fields of the CSR block: lanes_enable, lanes_number and the five timeouts.
- Produces LP line states, HS output enables and HS byte data, plus the burst_done and underflow event pulses.

Parameters:
- LANES, 4, number of physical data lanes (1..4).
- CNT_W, 8, width of timeout counter; equals the timeout field width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- lanes_enable  in  1  sequencer enable (level).
- lanes_number  in  3  active lanes, 1..LANES; 0 or >LANES is treated as LANES.
- tlpx_timeout  in  8  LP-01 duration, cycles.
- hs_prepare_timeout  in  8  LP-00 duration, cycles.
- hs_go_timeout  in  8  HS-zero duration, cycles.
- hs_trail_timeout  in  8  HS-trail duration, cycles.
- hs_exit_timeout  in  8  LP-11 hold after burst, cycles.
- hs_req  in  1  burst request from assembler (level).
- hs_valid  in  1  hs_data valid.
- hs_data  in  8*LANES  one byte per lane; lane i = [8i+7:8i].
- hs_ready  out  1  sequencer accepts hs_data.
- lp_p  out  LANES  LP Dp per lane.
- lp_n  out  LANES  LP Dn per lane.
- hs_oe  out  LANES  HS driver enable per lane.
- hs_dout  out  8*LANES  HS byte per lane.
- busy  out  1  state != IDLE.
- burst_done  out  1  one-cycle pulse on HS_EXIT→IDLE.
- underflow_set  out  1  one-cycle pulse on data underflow.

Behaviour:
- Reset (rst_n low at clk edge) applies in any state, including mid-burst:
  - state = IDLE; all counters cleared.
  - lp_p = lp_n = all 1 (LP-11); hs_oe = 0; hs_dout = 0.
  - hs_ready = 0, busy = 0, burst_done = 0, underflow_set = 0.
- States: IDLE, LP01, LP00, HS_ZERO, HS_DATA, HS_TRAIL, HS_EXIT.
- Timed states (LP01, LP00, HS_ZERO, HS_TRAIL, HS_EXIT):
  - Each lasts exactly T cycles, T = latched timeout; T = 0 is treated as 1.
  - The counter loads on entry and decrements each cycle; the state exits when the counter reaches 1.
- IDLE → LP01 when lanes_enable & hs_req.
  - On this transition, latch all five timeouts and the effective lane count.
  - CSR changes during a burst have no effect on that burst.
- LP01 → LP00 → HS_ZERO → HS_DATA in sequence, each on timeout.
- HS_DATA:
  - hs_ready = 1 (combinational, from state). A transfer occurs when hs_valid & hs_ready; hs_dout captures hs_data.
  - Leaves for HS_TRAIL on the first cycle with hs_valid = 0. On that cycle:
    - hs_req = 1 and lanes_enable = 1 → underflow_set pulses.
    - hs_req = 0 → normal end, no pulse.
  - lanes_enable = 0 → go to HS_TRAIL regardless of hs_valid; no transfer that cycle; no underflow pulse.
- HS_TRAIL → HS_EXIT → IDLE on timeout; burst_done pulses on the HS_EXIT→IDLE transition.
- lanes_enable low in LP01/LP00/HS_ZERO does not abort; the sequence runs to HS_DATA, which then ends immediately.
- Re-entry: in IDLE, a held hs_req with lanes_enable restarts LP01 on the next cycle. The minimum gap is the single IDLE cycle.
- PHY outputs are registered. The output at cycle n+1 reflects state and data at cycle n. Decode per active lane:
  - IDLE/HS_EXIT: LP-11, hs_oe = 0.
  - LP01: lp_p = 0, lp_n = 1.
  - LP00: lp_p = 0, lp_n = 0.
  - HS_ZERO: hs_oe = 1, byte = 0x00.
  - HS_DATA: hs_oe = 1, byte = last transferred byte.
  - HS_TRAIL: hs_oe = 1, byte = {8{~b7}}, where b7 = bit 7 of that lane's last transferred byte; b7 = 0 if no transfer occurred.
  - In all HS states lp_p = lp_n = 0.
- Inactive lanes (index ≥ effective count): always LP-11, hs_oe = 0, byte = 0.
- busy is registered (state != IDLE) and is low in the cycle after burst_done.

Test Plan:
- Defaults tlpx = 8, prep = 15, go = 30, trail = 2, exit = 3; lanes = 4; hs_req with 4 valid beats 0x11223344..0x44556677 then hs_req = 0:
  - LP01 for 8 cycles, LP00 for 15, HS_ZERO for 30, 4 accepted beats, trail bytes 0xFF/0xFF/0xFF/0xFF (b7 of 0x44556677 lanes = 0), exit for 3.
  - One burst_done pulse.
- All timeouts = 0 → every timed state lasts 1 cycle; IDLE-to-first-hs_ready latency = 4 cycles.
- lanes_number = 2, data byte 0x80 on lanes 0–1:
  - Lanes 2–3 stay LP-11 with hs_oe = 0 throughout.
  - Trail bytes on lanes 0–1 = 0x00.
- hs_req held high, hs_valid dropped after 3 beats → underflow_set pulses once; HS_TRAIL entered next cycle; burst_done follows after trail + exit.
- tlpx_timeout rewritten from 8 to 2 during LP00 → the current burst is unchanged; the next burst uses LP01 = 2 cycles.
- rst_n low for 1 cycle mid-HS_DATA → next cycle LP-11 on all lanes, hs_oe = 0, hs_ready = 0, no burst_done pulse.
